// File: rtl/alu_ctrl.sv
// Command sequencer and accumulator owner for a registered ALU: accepts one command per
// handshake, issues it to the ALU, captures the result and offers it on a result handshake.
module alu_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic          i_in_ld,
    input  logic [2:0]    i_in_op,
    input  logic [DW-1:0] i_in_data,
    output logic [2:0]    o_alu_op,
    output logic [DW-1:0] o_alu_data,
    output logic [DW-1:0] o_alu_accum,
    output logic          o_alu_reset,
    input  logic [DW-1:0] i_alu_y,
    input  logic          i_alu_zero,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [DW-1:0] o_res_y,
    output logic          o_res_zero,
    output logic [DW-1:0] o_accum_out
);

    // WAIT counts 0 .. ALU_LAT-2, giving ALU_LAT-1 extra cycles before capture.
    localparam int unsigned CW = (ALU_LAT > 2) ? $clog2(ALU_LAT - 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((ALU_LAT > 1) ? (ALU_LAT - 2) : 0);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StHold
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [2:0]    r_op;
    logic [2:0]    w_op_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic [DW-1:0] r_accum;
    logic [DW-1:0] w_accum_nxt;
    logic [DW-1:0] r_res_y;
    logic [DW-1:0] w_res_y_nxt;
    logic          r_res_zero;
    logic          w_res_zero_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_op       <= '0;
            r_data     <= '0;
            r_accum    <= '0;
            r_res_y    <= '0;
            r_res_zero <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_data     <= w_data_nxt;
            r_accum    <= w_accum_nxt;
            r_res_y    <= w_res_y_nxt;
            r_res_zero <= w_res_zero_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_data_nxt     = r_data;
        w_accum_nxt    = r_accum;
        w_res_y_nxt    = r_res_y;
        w_res_zero_nxt = r_res_zero;
        w_cnt_nxt      = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_in_valid) begin
                    w_op_nxt   = i_in_op;
                    w_data_nxt = i_in_data;
                    if (i_in_ld) begin
                        w_accum_nxt    = i_in_data;
                        w_res_y_nxt    = i_in_data;
                        w_res_zero_nxt = (i_in_data == '0);
                        w_state_nxt    = StHold;
                    end else begin
                        w_state_nxt = StIssue;
                    end
                end
            end
            StIssue: begin
                if (ALU_LAT > 1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StWait;
                end else begin
                    w_state_nxt = StCapture;
                end
            end
            StWait: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state_nxt = StCapture;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            StCapture: begin
                w_accum_nxt    = i_alu_y;
                w_res_y_nxt    = i_alu_y;
                w_res_zero_nxt = i_alu_zero;
                w_state_nxt    = StHold;
            end
            StHold: begin
                if (i_res_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_res_valid = (r_state == StHold);
    assign o_alu_op    = r_op;
    assign o_alu_data  = r_data;
    assign o_alu_accum = r_accum;
    assign o_alu_reset = ~i_reset;
    assign o_res_y     = r_res_y;
    assign o_res_zero  = r_res_zero;
    assign o_accum_out = r_accum;

endmodule
